// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle shift-add multiplier and restoring divider owning HI/LO.
// Works on operand magnitudes; sign correction is folded into the edge that enters DONE.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_q, r_hi, r_lo;
  logic [WIDTH:0]   r_p;
  logic             r_neg_q, r_neg_r, r_dbz;
  logic             w_sa, w_sb, w_zero, w_accept, w_busy, w_last, w_ok;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_mul_q, w_div_q, w_quo, w_rem;
  logic [WIDTH:0]   w_sum, w_mul_p, w_sh, w_div_p;
  logic [WIDTH+1:0] w_diff;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  always_comb begin
    w_sa     = op[1] & a[WIDTH-1];
    w_sb     = op[1] & b[WIDTH-1];
    w_a_mag  = w_sa ? -a : a;
    w_b_mag  = w_sb ? -b : b;
    w_zero   = op[0] && b == '0;
    w_busy   = r_state == MUL || r_state == DIV;
    w_accept = !w_busy && start;
    w_last   = r_cnt == CW'(WIDTH - 1);
    w_sum    = r_p + (r_q[0] ? {1'b0, r_a} : '0);
    w_mul_p  = {1'b0, w_sum[WIDTH:1]};
    w_mul_q  = {w_sum[0], r_q[WIDTH-1:1]};
    w_sh     = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    w_diff   = {1'b0, w_sh} - {2'b0, r_b};
    w_ok     = !w_diff[WIDTH+1];
    w_div_p  = w_ok ? w_diff[WIDTH:0] : w_sh;
    w_div_q  = {r_q[WIDTH-2:0], w_ok};
    w_prod   = {w_mul_p[WIDTH-1:0], w_mul_q};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_quo    = r_neg_q ? -w_div_q : w_div_q;
    w_rem    = r_neg_r ? -w_div_p[WIDTH-1:0] : w_div_p[WIDTH-1:0];
    w_next   = IDLE;
    if (w_accept) w_next = w_zero ? DONE : (op[0] ? DIV : MUL);
    else if (w_busy) w_next = w_last ? DONE : r_state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= '0;
        r_a     <= w_a_mag;
        r_b     <= w_b_mag;
        r_p     <= '0;
        r_q     <= op[0] ? w_a_mag : w_b_mag;
        r_neg_q <= w_sa ^ w_sb;
        r_neg_r <= w_sa;
        r_dbz   <= w_zero;
        if (w_zero) begin
          r_hi <= a;
          r_lo <= '1;
        end
      end else if (w_busy) begin
        r_cnt <= r_cnt + CW'(1);
        r_p   <= r_state == MUL ? w_mul_p : w_div_p;
        r_q   <= r_state == MUL ? w_mul_q : w_div_q;
        if (w_last) begin
          r_hi <= r_state == MUL ? w_prod_s[2*WIDTH-1:WIDTH] : w_rem;
          r_lo <= r_state == MUL ? w_prod_s[WIDTH-1:0] : w_quo;
        end
      end
    end
  end
  assign busy        = w_busy;
  assign done        = r_state == DONE;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors against an arithmetic reference model of muldiv_sequencer.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int n_chk = 0, n_fail = 0;
  logic        armed = 1'b0;
  int          m_n = 0;
  logic        m_done = 1'b0, m_dbz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_p = '0;
  logic [64:0] mres;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = o[1] ? longint'($signed(x)) : longint'({32'b0, x});
    sy = o[1] ? longint'($signed(y)) : longint'({32'b0, y});
    if (!o[0]) begin
      q = sx * sy;
      return {1'b0, q[63:0]};
    end
    if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
    q = sx / sy;
    r = sx % sy;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  assign mres = model(op, a, b);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_n <= 0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_dbz <= 1'b0;
    end else if (m_n != 0) begin
      m_n    <= m_n - 1;
      m_done <= (m_n == 1);
      if (m_n == 1) begin
        m_hi <= m_p[63:32];
        m_lo <= m_p[31:0];
      end
    end else begin
      m_done <= start && mres[64];
      if (start) begin
        m_dbz <= mres[64];
        if (mres[64]) begin
          m_hi <= mres[63:32];
          m_lo <= mres[31:0];
        end else begin
          m_p <= mres[63:0];
          m_n <= 32;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 64'(busy), 64'(m_n != 0));
      chk("done", 64'(done), 64'(m_done));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    end
  end

  task automatic run(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int exp_lat, input logic [31:0] eh, input logic [31:0] el, input logic ed,
                     input bit inj);
    int lat = 0;
    start = 1'b1; op = o; a = x; b = y;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a = $urandom;
        b = $urandom;
      end
      if (inj && k == 10) begin
        start = 1'b1; a = 32'd3; b = 32'd3;
      end else if (inj && k == 11) start = 1'b0;
      if (done) lat = k;
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    chk({nm, " dbz"}, 64'(div_by_zero), 64'(ed));
  endtask

  initial begin
    int pulses;
    @(posedge clk);
    armed = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset hi", 64'(hi), 64'h0);
    chk("reset lo", 64'(lo), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset done", 64'(done), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    run("multu 12*4", 2'b00, 32'd12, 32'd4, 33, 32'h0, 32'd48, 1'b0, 1'b0);
    run("multu max*max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0);
    run("divu 13/4", 2'b01, 32'd13, 32'd4, 33, 32'd1, 32'd3, 1'b0, 1'b0);
    run("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run("mult -3*5", 2'b10, 32'hFFFF_FFFD, 32'd5, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
    run("div min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
    run("div 7/-2", 2'b11, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run("divu 9/0", 2'b01, 32'd9, 32'd0, 1, 32'd9, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run("multu 6*7 busy start", 2'b00, 32'd6, 32'd7, 33, 32'h0, 32'd42, 1'b0, 1'b1);
    run("divu 100/7 b2b", 2'b01, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 1'b0);
    run("divu 13/4 pre-reset", 2'b01, 32'd13, 32'd4, 33, 32'd1, 32'd3, 1'b0, 1'b0);
    start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid reset busy", 64'(busy), 64'h0);
    chk("mid reset done", 64'(done), 64'h0);
    chk("mid reset hi", 64'(hi), 64'h0);
    chk("mid reset lo", 64'(lo), 64'h0);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("no done after reset", 64'(pulses), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

- Multi-cycle multiply/divide unit owning the HI/LO register pair used by the ALU's move-from-HI/LO operations.
- Replaces the single-cycle combinational `*`, `/` and `%` with a 32-iteration shift-add multiplier and a 32-iteration restoring divider.
- A start/busy/done handshake lets the control unit stall the pipeline while an operation runs.
- Supports signed and unsigned variants. Results sit in HI/LO until the next operation completes.

## Interface

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports (clock and reset first):
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only while the unit is not busy.
- op  input  2  00 MULTU, 01 DIVU, 10 MULT (signed), 11 DIV (signed); sampled with start.
- a  input  WIDTH  multiplicand or dividend; sampled with start.
- b  input  WIDTH  multiplier or divisor; sampled with start.
- busy  output  1  operation in progress; start is ignored while high.
- done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- div_by_zero  output  1  set with done when a divide had b==0; cleared at the next accepted start.
- hi  output  WIDTH  HI register: product upper half, or remainder.
- lo  output  WIDTH  LO register: product lower half, or quotient.

## Operation

- States:
  - IDLE: busy=0, done=0.
  - MUL: busy=1.
  - DIV: busy=1.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE/DONE with start=1: latch operands and op, clear the 5-bit iteration counter, go to MUL (op[0]=0) or DIV (op[0]=1).
  - IDLE/DONE with start=0: go to IDLE.
  - DIV with b==0 at acceptance: go to DONE on the next edge with no iterations.
  - MUL/DIV: go to DONE after the counter reaches 31, i.e. after 32 iterations.
- Signed ops (op[1]=1): the unit works on magnitudes and records sign_a and sign_b at acceptance.
  - MULT: product is negated (64-bit two's complement) when sign_a^sign_b.
  - DIV: quotient is negated when sign_a^sign_b. Remainder is negated when sign_a (truncating division).
  - -2^31 / -1 yields lo=0x80000000, hi=0; no trap.
- Multiply: 64-bit accumulator with upper 33 bits plus a lower 32-bit register initialised to |b|. Each iteration:
  - if the lower register's lsb is 1, add |a| to the upper 33 bits;
  - shift the whole accumulator right by 1.
- Divide (restoring): 33-bit remainder cleared, quotient register initialised to |a|. Each iteration:
  - shift {rem, quot} left by 1;
  - trial-subtract |b|;
  - if the result is non-negative, keep it and set quotient lsb to 1; otherwise restore.
- HI/LO update only on entry to DONE, with sign correction applied in that same edge. They hold otherwise and are not disturbed by an operation in flight.
- Divide by zero: hi=a (raw), lo=0xFFFFFFFF, div_by_zero=1.
- Arithmetic is internal to the unit; a and b may change after the start cycle without effect.

## Timing

- Reset (rst_n=0 at an edge), including mid-operation: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0. The in-flight operation is discarded.
- Start accepted in cycle 0 (edge E0):
  - busy=1 in cycles 1..32;
  - done=1 and new hi/lo in cycle 33;
  - latency 33 cycles from acceptance to done, for every op including multiply by zero.
- Divide by zero: done=1 in cycle 1; busy never asserts.
- start while busy=1: ignored, with no effect on the operation or the operand latches.
- start in the DONE cycle is accepted, giving back-to-back operations every 33 cycles.
- done is exactly one cycle long, never coincides with busy, and is not held off by start.

## Test plan

- MULTU a=12, b=4: done in cycle 33, hi=0, lo=48. Then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
- DIVU a=13, b=4: lo=3, hi=1, div_by_zero=0. DIV a=-7 (0xFFFFFFF9), b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MULT a=-3, b=5: hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU a=9, b=0:
  - done in cycle 1, busy stays 0, hi=9, lo=0xFFFFFFFF, div_by_zero=1;
  - the next accepted start clears div_by_zero.
- Busy and back-to-back:
  - start MULTU 6*7, pulse start with different operands at cycle 10: ignored; result lo=42 at cycle 33;
  - start DIVU 100/7 in the done cycle: lo=14, hi=2 exactly 33 cycles later.
- Reset:
  - prior result hi=1, lo=3; start DIVU; drive rst_n=0 at cycle 15;
  - next cycle: busy=0, done=0, hi=0, lo=0, and no done pulse follows.
